vx_issue_scoreboard: RTL and testbench



---
 rtl/vx_issue_scoreboard_pkg.sv | 52 +++++
 rtl/vx_issue_scoreboard_pipe_register.sv | 17 +
 rtl/vx_issue_scoreboard.sv | 157 +++++++++++++++
 tb/tb_vx_issue_scoreboard.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_issue_scoreboard_pkg.sv
// Shared types and sizing for the issue-slice scoreboard.
package vx_issue_scoreboard_pkg;

    localparam int NUM_WARPS       = 8;
    localparam int ISSUE_WIDTH     = 2;
    localparam int ISSUE_NUM_WARPS = NUM_WARPS / ISSUE_WIDTH;
    localparam int ISSUE_WIS_W     = $clog2(ISSUE_NUM_WARPS);
    localparam int ISSUE_ISW_W     = $clog2(ISSUE_WIDTH);
    localparam int NW_WIDTH        = $clog2(NUM_WARPS);
    localparam int NR_BITS         = 6;
    localparam int NUM_THREADS     = 4;
    localparam int UUID_WIDTH      = 44;
    localparam int EX_BITS         = 2;
    localparam int INST_OP_BITS    = 4;
    localparam int INST_MOD_BITS   = 3;
    localparam int XLEN            = 32;
    localparam int PERF_CTR_BITS   = 44;

    typedef struct packed {
        logic [UUID_WIDTH-1:0]    uuid;
        logic [ISSUE_WIS_W-1:0]   wis;
        logic [NUM_THREADS-1:0]   tmask;
        logic [EX_BITS-1:0]       ex_type;
        logic [INST_OP_BITS-1:0]  op_type;
        logic [INST_MOD_BITS-1:0] op_mod;
        logic                     wb;
        logic                     use_pc;
        logic                     use_imm;
        logic [XLEN-1:0]          pc;
        logic [XLEN-1:0]          imm;
        logic [NR_BITS-1:0]       rd;
        logic [NR_BITS-1:0]       rs1;
        logic [NR_BITS-1:0]       rs2;
        logic [NR_BITS-1:0]       rs3;
    } scoreboard_data_t;

    localparam int SCB_DATAW = $bits(scoreboard_data_t);

    function automatic logic [ISSUE_WIS_W-1:0] wid_to_wis(
        input logic [NW_WIDTH-1:0] wid
    );
        return wid[NW_WIDTH-1:ISSUE_ISW_W];
    endfunction

    function automatic logic [NW_WIDTH-1:0] wis_to_wid(
        input logic [ISSUE_WIS_W-1:0] wis,
        input logic [ISSUE_ISW_W-1:0] isw
    );
        return {wis, isw};
    endfunction

endpackage

// File: rtl/vx_issue_scoreboard_pipe_register.sv
// One-entry data register with load enable; contents are don't-care after reset.
module vx_issue_scoreboard_pipe_register #(
    parameter int DATAW = 1
) (
    input  logic             clk,
    input  logic             enable,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out
);

    always_ff @(posedge clk) begin
        if (enable) begin
            data_out <= data_in;
        end
    end

endmodule

// File: rtl/vx_issue_scoreboard.sv
// Per-slice issue scoreboard: RAW/WAW hazard stall with writeback bypass.
// Optional SCOREBOARD_PERF_EN adds stall performance counters.
module vx_issue_scoreboard
    import vx_issue_scoreboard_pkg::*;
#(
    parameter int CORE_ID  = 0,
    parameter int ISSUE_ID = 0,
    parameter int NUM_WIS  = ISSUE_NUM_WARPS,
    parameter int NUM_REGS = (1 << NR_BITS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ibuffer_if_valid,
    input  scoreboard_data_t       ibuffer_if_data,
    output logic                   ibuffer_if_ready,
    input  logic                   writeback_if_valid,
    input  logic [ISSUE_WIS_W-1:0] writeback_if_wis,
    input  logic [NR_BITS-1:0]     writeback_if_rd,
    input  logic                   writeback_if_eop,
    output logic                   scoreboard_if_valid,
    output scoreboard_data_t       scoreboard_if_data,
    input  logic                   scoreboard_if_ready
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0] perf_stalls,
    output logic [PERF_CTR_BITS-1:0] perf_units_stalls
`endif
);

    logic [NUM_WIS-1:0][NUM_REGS-1:0] pending;
    logic [NUM_WIS-1:0][NUM_REGS-1:0] clr_mask;
    logic [NUM_WIS-1:0][NUM_REGS-1:0] set_mask;
    logic [NUM_WIS-1:0][NUM_REGS-1:0] pend_eff;

    logic             out_valid;
    scoreboard_data_t out_data;
    scoreboard_data_t head;
    logic             hazard;
    logic             in_fire;
    logic             out_fire;

    assign head = ibuffer_if_data;

    always_comb begin
        clr_mask = '0;
        if (writeback_if_valid && writeback_if_eop
            && writeback_if_rd != '0) begin
            clr_mask[writeback_if_wis][writeback_if_rd] = 1'b1;
        end
    end

    // Same-cycle writebacks release the head without waiting a cycle.
    assign pend_eff = pending & ~clr_mask;

    always_comb begin
        hazard = 1'b0;
        if (ibuffer_if_valid) begin
            hazard = pend_eff[head.wis][head.rs1]
                   | pend_eff[head.wis][head.rs2]
                   | pend_eff[head.wis][head.rs3]
                   | (head.wb & pend_eff[head.wis][head.rd]);
        end
    end

    assign ibuffer_if_ready = !reset && !hazard
                            && (!out_valid || scoreboard_if_ready);
    assign in_fire  = ibuffer_if_valid && ibuffer_if_ready;
    assign out_fire = out_valid && scoreboard_if_ready;

    always_comb begin
        set_mask = '0;
        if (in_fire && head.wb && head.rd != '0) begin
            set_mask[head.wis][head.rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= '0;
            out_valid <= 1'b0;
        end else begin
            pending <= pend_eff | set_mask;
            if (in_fire) begin
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

    vx_issue_scoreboard_pipe_register #(
        .DATAW (SCB_DATAW)
    ) u_out_reg (
        .clk      (clk),
        .enable   (in_fire),
        .data_in  (ibuffer_if_data),
        .data_out (out_data)
    );

    assign scoreboard_if_valid = out_valid;
    assign scoreboard_if_data  = out_data;

`ifdef SCOREBOARD_PERF_EN
    logic units_stall;
    assign units_stall = out_valid && !scoreboard_if_ready
                       && ibuffer_if_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stalls       <= '0;
            perf_units_stalls <= '0;
        end else begin
            if (hazard && perf_stalls != '1) begin
                perf_stalls <= perf_stalls + PERF_CTR_BITS'(1);
            end
            if (units_stall && perf_units_stalls != '1) begin
                perf_units_stalls <= perf_units_stalls + PERF_CTR_BITS'(1);
            end
        end
    end
`endif

`ifndef SYNTHESIS
    scoreboard_data_t prev_data;
    logic             prev_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            prev_stall <= out_valid && !scoreboard_if_ready;
        end
        prev_data <= out_data;
    end

    // A bypassed clear may coincide with a set; a still-pending target may not.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ((set_mask & pend_eff) == '0)
            else $error("core%0d issue%0d: set on pending register",
                        CORE_ID, ISSUE_ID);
            if (writeback_if_valid && writeback_if_rd != '0) begin
                assert (pending[writeback_if_wis][writeback_if_rd])
                else $error("core%0d issue%0d: writeback to idle wis=%0d rd=%0d",
                            CORE_ID, ISSUE_ID,
                            writeback_if_wis, writeback_if_rd);
            end
            if (prev_stall) begin
                assert (out_valid && out_data == prev_data)
                else $error("core%0d issue%0d: output changed under backpressure",
                            CORE_ID, ISSUE_ID);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vx_issue_scoreboard.sv
// Directed self-checking bench for vx_issue_scoreboard.
`timescale 1ns/1ps
module tb_vx_issue_scoreboard;
    import vx_issue_scoreboard_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   ib_valid;
    scoreboard_data_t       ib_data;
    logic                   ib_ready;
    logic                   wb_valid;
    logic [ISSUE_WIS_W-1:0] wb_wis;
    logic [NR_BITS-1:0]     wb_rd;
    logic                   wb_eop;
    logic                   sb_valid;
    scoreboard_data_t       sb_data;
    logic                   sb_ready;
`ifdef SCOREBOARD_PERF_EN
    logic [PERF_CTR_BITS-1:0] perf_stalls;
    logic [PERF_CTR_BITS-1:0] perf_units_stalls;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vx_issue_scoreboard dut (
        .clk                 (clk),
        .reset               (reset),
        .ibuffer_if_valid    (ib_valid),
        .ibuffer_if_data     (ib_data),
        .ibuffer_if_ready    (ib_ready),
        .writeback_if_valid  (wb_valid),
        .writeback_if_wis    (wb_wis),
        .writeback_if_rd     (wb_rd),
        .writeback_if_eop    (wb_eop),
        .scoreboard_if_valid (sb_valid),
        .scoreboard_if_data  (sb_data),
        .scoreboard_if_ready (sb_ready)
`ifdef SCOREBOARD_PERF_EN
        ,
        .perf_stalls         (perf_stalls),
        .perf_units_stalls   (perf_units_stalls)
`endif
    );

    function automatic scoreboard_data_t mk(
        input int uuid, input int wis, input bit wb,
        input int rd, input int rs1, input int rs2, input int rs3
    );
        scoreboard_data_t d;
        d         = '0;
        d.uuid    = UUID_WIDTH'(uuid);
        d.wis     = ISSUE_WIS_W'(wis);
        d.tmask   = 4'hF;
        d.op_type = 4'(uuid);
        d.wb      = wb;
        d.pc      = 32'h8000_0000 + 32'(uuid * 4);
        d.imm     = 32'(uuid * 3);
        d.rd      = NR_BITS'(rd);
        d.rs1     = NR_BITS'(rs1);
        d.rs2     = NR_BITS'(rs2);
        d.rs3     = NR_BITS'(rs3);
        return d;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ib_valid = 1'b1;
        ib_data = mk(99, 0, 1'b0, 0, 0, 0, 0);
        cyc();
        smp();
        checks++;
        if (sb_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", sb_valid);
        end
        checks++;
        if (ib_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=0", ib_ready);
        end
        cyc();
        reset = 1'b0;
        ib_valid = 1'b0;
    endtask

    task automatic test_raw();
        cyc();
        ib_valid = 1'b1;
        ib_data = mk(1, 0, 1'b1, 5, 0, 0, 0);
        smp();
        checks++;
        if (ib_ready !== 1'b1) begin
            failures++;
            $display("FAIL raw_first_ready got=%b exp=1", ib_ready);
        end
        cyc();
        ib_data = mk(2, 0, 1'b0, 0, 5, 0, 0);
        smp();
        checks++;
        if ({sb_valid, sb_data.uuid} !== {1'b1, 44'd1}) begin
            failures++;
            $display("FAIL raw_first_out got=%b/%0d exp=1/1",
                     sb_valid, sb_data.uuid);
        end
        checks++;
        if (ib_ready !== 1'b0) begin
            failures++;
            $display("FAIL raw_stall got=%b exp=0", ib_ready);
        end
        cyc();
        smp();
        checks++;
        if (ib_ready !== 1'b0) begin
            failures++;
            $display("FAIL raw_stall_hold got=%b exp=0", ib_ready);
        end
        cyc();
        wb_valid = 1'b1;
        wb_wis = 2'd0;
        wb_rd = 6'd5;
        wb_eop = 1'b1;
        smp();
        checks++;
        if (ib_ready !== 1'b1) begin
            failures++;
            $display("FAIL raw_bypass got=%b exp=1", ib_ready);
        end
        cyc();
        wb_valid = 1'b0;
        ib_valid = 1'b0;
        smp();
        checks++;
        if ({sb_valid, sb_data.uuid} !== {1'b1, 44'd2}) begin
            failures++;
            $display("FAIL raw_out got=%b/%0d exp=1/2",
                     sb_valid, sb_data.uuid);
        end
    endtask

    task automatic test_waw_partial();
        cyc();
        ib_valid = 1'b1;
        ib_data = mk(3, 0, 1'b1, 7, 0, 0, 0);
        cyc();
        ib_data = mk(4, 0, 1'b1, 7, 0, 0, 0);
        smp();
        checks++;
        if (ib_ready !== 1'b0) begin
            failures++;
            $display("FAIL waw_stall got=%b exp=0", ib_ready);
        end
        cyc();
        wb_valid = 1'b1;
        wb_wis = 2'd0;
        wb_rd = 6'd7;
        wb_eop = 1'b0;
        smp();
        checks++;
        if (ib_ready !== 1'b0) begin
            failures++;
            $display("FAIL waw_no_eop got=%b exp=0", ib_ready);
        end
        cyc();
        wb_eop = 1'b1;
        smp();
        checks++;
        if (ib_ready !== 1'b1) begin
            failures++;
            $display("FAIL waw_release got=%b exp=1", ib_ready);
        end
        cyc();
        wb_valid = 1'b0;
        ib_valid = 1'b0;
        smp();
        checks++;
        if ({sb_valid, sb_data.uuid} !== {1'b1, 44'd4}) begin
            failures++;
            $display("FAIL waw_out got=%b/%0d exp=1/4",
                     sb_valid, sb_data.uuid);
        end
        cyc();
        wb_valid = 1'b1;
        wb_rd = 6'd7;
        wb_eop = 1'b1;
        cyc();
        wb_valid = 1'b0;
    endtask

    task automatic test_x0_cross_warp();
        cyc();
        ib_valid = 1'b1;
        ib_data = mk(5, 1, 1'b1, 0, 0, 0, 0);
        smp();
        checks++;
        if (ib_ready !== 1'b1) begin
            failures++;
            $display("FAIL x0_write got=%b exp=1", ib_ready);
        end
        cyc();
        ib_data = mk(6, 1, 1'b0, 0, 0, 0, 0);
        smp();
        checks++;
        if (ib_ready !== 1'b1) begin
            failures++;
            $display("FAIL x0_read got=%b exp=1", ib_ready);
        end
        cyc();
        ib_data = mk(7, 0, 1'b1, 3, 0, 0, 0);
        smp();
        checks++;
        if ({sb_valid, sb_data.uuid} !== {1'b1, 44'd6}) begin
            failures++;
            $display("FAIL x0_back_to_back got=%b/%0d exp=1/6",
                     sb_valid, sb_data.uuid);
        end
        cyc();
        ib_data = mk(8, 1, 1'b0, 0, 3, 0, 0);
        smp();
        checks++;
        if (ib_ready !== 1'b1) begin
            failures++;
            $display("FAIL cross_warp got=%b exp=1", ib_ready);
        end
        cyc();
        ib_valid = 1'b0;
        wb_valid = 1'b1;
        wb_wis = 2'd0;
        wb_rd = 6'd3;
        wb_eop = 1'b1;
        smp();
        checks++;
        if ({sb_valid, sb_data.uuid} !== {1'b1, 44'd8}) begin
            failures++;
            $display("FAIL cross_out got=%b/%0d exp=1/8",
                     sb_valid, sb_data.uuid);
        end
        cyc();
        wb_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        scoreboard_data_t a;
        a = mk(10, 2, 1'b0, 0, 1, 2, 0);
        cyc();
        sb_ready = 1'b0;
        ib_valid = 1'b1;
        ib_data = a;
        smp();
        checks++;
        if (ib_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_capture got=%b exp=1", ib_ready);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 0) ib_data = mk(11, 2, 1'b0, 0, 1, 2, 0);
            smp();
            checks++;
            if (sb_valid !== 1'b1 || sb_data !== a) begin
                failures++;
                $display("FAIL bp_hold%0d got=%b/%0d exp=1/10",
                         i, sb_valid, sb_data.uuid);
            end
            checks++;
            if (ib_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_block%0d got=%b exp=0", i, ib_ready);
            end
        end
        cyc();
        sb_ready = 1'b1;
        smp();
        checks++;
        if (ib_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_resume got=%b exp=1", ib_ready);
        end
        cyc();
        ib_data = mk(12, 2, 1'b0, 0, 0, 0, 0);
        smp();
        checks++;
        if ({sb_valid, sb_data.uuid, ib_ready} !== {1'b1, 44'd11, 1'b1}) begin
            failures++;
            $display("FAIL bp_flow1 got=%b/%0d/%b exp=1/11/1",
                     sb_valid, sb_data.uuid, ib_ready);
        end
        cyc();
        ib_valid = 1'b0;
        smp();
        checks++;
        if ({sb_valid, sb_data.uuid} !== {1'b1, 44'd12}) begin
            failures++;
            $display("FAIL bp_flow2 got=%b/%0d exp=1/12",
                     sb_valid, sb_data.uuid);
        end
        cyc();
        smp();
        checks++;
        if (sb_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain got=%b exp=0", sb_valid);
        end
    endtask

    task automatic test_reset_mid();
        cyc();
        sb_ready = 1'b0;
        ib_valid = 1'b1;
        ib_data = mk(20, 0, 1'b1, 9, 0, 0, 0);
        cyc();
        ib_valid = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        ib_valid = 1'b1;
        ib_data = mk(21, 0, 1'b0, 0, 9, 0, 0);
        smp();
        checks++;
        if (sb_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_out_drop got=%b exp=0", sb_valid);
        end
        checks++;
        if (ib_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_pending_clear got=%b exp=1", ib_ready);
        end
        cyc();
        ib_valid = 1'b0;
        sb_ready = 1'b1;
        smp();
        checks++;
        if ({sb_valid, sb_data.uuid} !== {1'b1, 44'd21}) begin
            failures++;
            $display("FAIL rst_issue got=%b/%0d exp=1/21",
                     sb_valid, sb_data.uuid);
        end
    endtask

`ifdef SCOREBOARD_PERF_EN
    task automatic test_perf();
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        smp();
        checks++;
        if (perf_stalls !== '0) begin
            failures++;
            $display("FAIL perf_reset got=%0d exp=0", perf_stalls);
        end
        cyc();
        ib_valid = 1'b1;
        ib_data = mk(30, 3, 1'b1, 11, 0, 0, 0);
        cyc();
        ib_data = mk(31, 3, 1'b0, 0, 0, 0, 11);
        repeat (9) cyc();
        cyc();
        wb_valid = 1'b1;
        wb_wis = 2'd3;
        wb_rd = 6'd11;
        wb_eop = 1'b1;
        smp();
        checks++;
        if (perf_stalls !== PERF_CTR_BITS'(10)) begin
            failures++;
            $display("FAIL perf_stalls got=%0d exp=10", perf_stalls);
        end
        checks++;
        if (perf_units_stalls !== '0) begin
            failures++;
            $display("FAIL perf_units got=%0d exp=0", perf_units_stalls);
        end
        cyc();
        wb_valid = 1'b0;
        ib_valid = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b1;
        ib_valid = 1'b0;
        ib_data = '0;
        wb_valid = 1'b0;
        wb_wis = '0;
        wb_rd = '0;
        wb_eop = 1'b0;
        sb_ready = 1'b1;
        test_reset();
        test_raw();
        test_waw_partial();
        test_x0_cross_warp();
        test_backpressure();
        test_reset_mid();
`ifdef SCOREBOARD_PERF_EN
        test_perf();
`endif
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
